// File: rtl/kbd_ascii_fifo.sv
// PS/2 key events -> ASCII characters queued in a first-word-fall-through FIFO.
// Latency: a mappable make is written at its own edge; visible at the head the next cycle.
// Backpressure: none upstream; when full without a pop the character is dropped and overflow is set.

// Generic synchronous FIFO: FWFT head, push accepted when full if a pop frees a slot.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_dat,
  input  logic              rd_en,
  output logic [W-1:0]      rd_dat,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees a slot, so a push is still accepted when full in the same cycle.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  assign rd_dat = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since reads are masked by empty.
  always_ff @(posedge clk) begin
    if (rst && !clr && do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers, occupancy and sticky overflow; clr discards same-cycle traffic.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && !do_push) overflow <= 1'b1;
    end
  end
endmodule

module kbd_ascii_fifo #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter bit SHIFT_SYMBOLS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic              key_make,
  input  logic [8:0]        last_change,
  input  logic              clr,
  input  logic              rd_en,
  output logic [7:0]        ascii_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              caps_on,
  output logic              overflow
);
  logic       shift_l;
  logic       shift_r;
  logic       caps_held;
  logic       shift;
  logic       is_ext;
  logic [7:0] code;
  logic [7:0] ch_dat;
  logic       ch_vld;
  logic [7:0] letter;
  logic       is_letter;
  logic [3:0] digit;
  logic       is_digit;
  logic [7:0] symbol;

  assign shift  = shift_l | shift_r;
  assign is_ext = last_change[8];
  assign code   = last_change[7:0];

  // Modifier state; caps_held blocks typematic repeats from re-toggling Caps Lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_held <= 1'b0;
      caps_on   <= 1'b0;
    end else if (key_valid && !is_ext) begin
      case (code)
        8'h12: shift_l <= key_make;
        8'h59: shift_r <= key_make;
        8'h58: begin
          if (!key_make) begin
            caps_held <= 1'b0;
          end else if (!caps_held) begin
            caps_on   <= ~caps_on;
            caps_held <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Letter table: scan code to lower-case ASCII.
  always_comb begin
    letter    = 8'h00;
    is_letter = 1'b1;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: is_letter = 1'b0;
    endcase
  end

  // Digit table: scan code to digit value plus its US shifted symbol.
  always_comb begin
    digit    = 4'd0;
    symbol   = 8'h00;
    is_digit = 1'b1;
    case (code)
      8'h45: begin digit = 4'd0; symbol = 8'h29; end
      8'h16: begin digit = 4'd1; symbol = 8'h21; end
      8'h1E: begin digit = 4'd2; symbol = 8'h40; end
      8'h26: begin digit = 4'd3; symbol = 8'h23; end
      8'h25: begin digit = 4'd4; symbol = 8'h24; end
      8'h2E: begin digit = 4'd5; symbol = 8'h25; end
      8'h36: begin digit = 4'd6; symbol = 8'h5E; end
      8'h3D: begin digit = 4'd7; symbol = 8'h26; end
      8'h3E: begin digit = 4'd8; symbol = 8'h2A; end
      8'h46: begin digit = 4'd9; symbol = 8'h28; end
      default: is_digit = 1'b0;
    endcase
  end

  // Character select for make events; Shift/Caps state is the pre-event value.
  always_comb begin
    ch_dat = 8'h00;
    ch_vld = 1'b0;
    if (key_valid && key_make) begin
      if (is_ext) begin
        if (code == 8'h5A) begin
          ch_dat = 8'h0D;
          ch_vld = 1'b1;
        end
      end else if (is_letter) begin
        ch_dat = (shift ^ caps_on) ? (letter - 8'h20) : letter;
        ch_vld = 1'b1;
      end else if (is_digit) begin
        ch_dat = (shift && SHIFT_SYMBOLS) ? symbol : {4'h3, digit};
        ch_vld = 1'b1;
      end else begin
        case (code)
          8'h29: begin ch_dat = 8'h20; ch_vld = 1'b1; end
          8'h5A: begin ch_dat = 8'h0D; ch_vld = 1'b1; end
          8'h66: begin ch_dat = 8'h08; ch_vld = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (ch_vld),
    .wr_dat   (ch_dat),
    .rd_en    (rd_en),
    .rd_dat   (ascii_out),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );
endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Directed table-driven bench for kbd_ascii_fifo (DEPTH=4), two instances differing in SHIFT_SYMBOLS.
// Latency: every vector is applied for one cycle and checked 1ns after the following rising edge.
// Backpressure: fill/overflow/pop-while-full sequences are part of the vector table.
module tb_kbd_ascii_fifo;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_valid;
  logic              key_make;
  logic [8:0]        last_change;
  logic              clr;
  logic              rd_en;
  logic [7:0]        ascii_out,  ascii_out0;
  logic              empty,      empty0;
  logic              full,       full0;
  logic [ADDR_W:0]   count,      count0;
  logic              caps_on,    caps_on0;
  logic              overflow,   overflow0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kbd_ascii_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SHIFT_SYMBOLS(1'b1)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_make(key_make),
    .last_change(last_change), .clr(clr), .rd_en(rd_en),
    .ascii_out(ascii_out), .empty(empty), .full(full), .count(count),
    .caps_on(caps_on), .overflow(overflow)
  );

  kbd_ascii_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SHIFT_SYMBOLS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_make(key_make),
    .last_change(last_change), .clr(clr), .rd_en(rd_en),
    .ascii_out(ascii_out0), .empty(empty0), .full(full0), .count(count0),
    .caps_on(caps_on0), .overflow(overflow0)
  );

  typedef struct {
    logic       kv;
    logic       mk;
    logic [8:0] code;
    logic       rd;
    logic       cl;
    logic [7:0] ea;
    logic [7:0] ea0;
    int         ec;
    logic       ecaps;
    logic       eovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic kv, input logic mk, input logic [8:0] code,
                     input logic rd, input logic cl, input logic [7:0] ea,
                     input logic [7:0] ea0, input int ec, input logic ecaps,
                     input logic eovf);
    vec_t v;
    v.kv = kv; v.mk = mk; v.code = code; v.rd = rd; v.cl = cl;
    v.ea = ea; v.ea0 = ea0; v.ec = ec; v.ecaps = ecaps; v.eovf = eovf;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] ea, input logic [7:0] ea0,
                       input int ec, input logic ecaps, input logic eovf);
    logic [ADDR_W:0] c;
    logic ee, ef;
    c  = ec[ADDR_W:0];
    ee = (ec == 0);
    ef = (ec == DEPTH);
    checks++;
    if (ascii_out !== ea || count !== c || empty !== ee || full !== ef ||
        caps_on !== ecaps || overflow !== eovf || ascii_out0 !== ea0 ||
        count0 !== c || empty0 !== ee || full0 !== ef || caps_on0 !== ecaps ||
        overflow0 !== eovf) begin
      failures++;
      $display("FAIL %s: got ascii=%h ascii0=%h cnt=%0d/%0d empty=%b full=%b caps=%b ovf=%b ; want ascii=%h ascii0=%h cnt=%0d empty=%b full=%b caps=%b ovf=%b",
               name, ascii_out, ascii_out0, count, count0, empty, full, caps_on, overflow,
               ea, ea0, ec, ee, ef, ecaps, eovf);
    end
  endtask

  task automatic drive(input logic r, input logic kv, input logic mk, input logic [8:0] code,
                       input logic rd, input logic cl);
    @(negedge clk);
    rst = r; key_valid = kv; key_make = mk; last_change = code; rd_en = rd; clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_make = 1'b0; last_change = '0; clr = 1'b0; rd_en = 1'b0;

    //   kv  mk  code     rd  clr  ascii  ascii0 cnt caps ovf
    add(1, 1, 9'h01C, 0, 0, 8'h61, 8'h61, 1, 0, 0);  // 'a'
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 0, 0);  // pop to empty
    add(1, 1, 9'h012, 0, 0, 8'h00, 8'h00, 0, 0, 0);  // L shift down
    add(1, 1, 9'h032, 0, 0, 8'h42, 8'h42, 1, 0, 0);  // 'B'
    add(1, 0, 9'h012, 0, 0, 8'h42, 8'h42, 1, 0, 0);  // L shift up
    add(1, 1, 9'h032, 0, 0, 8'h42, 8'h42, 2, 0, 0);  // 'b' queued behind
    add(0, 0, 9'h000, 1, 0, 8'h62, 8'h62, 1, 0, 0);
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 9'h058, 0, 0, 8'h00, 8'h00, 0, 1, 0);  // caps toggles on
    add(1, 1, 9'h058, 0, 0, 8'h00, 8'h00, 0, 1, 0);  // typematic, no toggle
    add(1, 1, 9'h058, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    add(1, 0, 9'h058, 0, 0, 8'h00, 8'h00, 0, 1, 0);  // caps release
    add(1, 1, 9'h012, 0, 0, 8'h00, 8'h00, 0, 1, 0);  // shift + caps
    add(1, 1, 9'h015, 0, 0, 8'h71, 8'h71, 1, 1, 0);  // 'q'
    add(1, 1, 9'h016, 0, 0, 8'h71, 8'h71, 2, 1, 0);  // shift+1
    add(0, 0, 9'h000, 1, 0, 8'h21, 8'h31, 1, 1, 0);  // '!' vs '1'
    add(1, 0, 9'h012, 0, 0, 8'h21, 8'h31, 1, 1, 0);  // shift up
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    add(1, 1, 9'h015, 0, 0, 8'h51, 8'h51, 1, 1, 0);  // caps only: 'Q'
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    add(1, 1, 9'h15A, 0, 0, 8'h0D, 8'h0D, 1, 1, 0);  // keypad Enter
    add(1, 1, 9'h175, 0, 0, 8'h0D, 8'h0D, 1, 1, 0);  // E0 75 ignored
    add(1, 0, 9'h01C, 0, 0, 8'h0D, 8'h0D, 1, 1, 0);  // break ignored
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    add(1, 1, 9'h01C, 0, 0, 8'h41, 8'h41, 1, 1, 0);  // fill with 'A'
    add(1, 1, 9'h01C, 0, 0, 8'h41, 8'h41, 2, 1, 0);
    add(1, 1, 9'h01C, 0, 0, 8'h41, 8'h41, 3, 1, 0);
    add(1, 1, 9'h01C, 0, 0, 8'h41, 8'h41, 4, 1, 0);  // full
    add(1, 1, 9'h029, 0, 0, 8'h41, 8'h41, 4, 1, 1);  // dropped, overflow
    add(1, 1, 9'h029, 1, 0, 8'h41, 8'h41, 4, 1, 1);  // push+pop while full
    add(0, 0, 9'h000, 1, 0, 8'h41, 8'h41, 3, 1, 1);
    add(0, 0, 9'h000, 1, 0, 8'h41, 8'h41, 2, 1, 1);
    add(0, 0, 9'h000, 1, 0, 8'h20, 8'h20, 1, 1, 1);  // space is last
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 1, 1);
    add(1, 1, 9'h066, 0, 0, 8'h08, 8'h08, 1, 1, 1);  // backspace
    add(1, 1, 9'h045, 0, 0, 8'h08, 8'h08, 2, 1, 1);  // '0'
    add(1, 1, 9'h05A, 0, 0, 8'h08, 8'h08, 3, 1, 1);  // Enter
    add(1, 1, 9'h01C, 1, 1, 8'h00, 8'h00, 0, 1, 0);  // clr wins over push/pop
    add(1, 1, 9'h03D, 0, 0, 8'h37, 8'h37, 1, 1, 0);  // '7'
    add(0, 0, 9'h000, 1, 0, 8'h00, 8'h00, 0, 1, 0);
    add(1, 1, 9'h046, 1, 0, 8'h39, 8'h39, 1, 1, 0);  // pop on empty ignored

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'h00, 8'h00, 0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].kv, tbl[i].mk, tbl[i].code, tbl[i].rd, tbl[i].cl);
      check($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ea0, tbl[i].ec, tbl[i].ecaps, tbl[i].eovf);
    end

    // Mid-stream reset overrides a same-cycle key event and pop.
    drive(1'b0, 1'b1, 1'b1, 9'h01C, 1'b1, 1'b0);
    check("mid_reset", 8'h00, 8'h00, 0, 1'b0, 1'b0);

    // Caps cleared by reset: letter comes out lower case again.
    drive(1'b1, 1'b1, 1'b1, 9'h01C, 1'b0, 1'b0);
    check("post_reset_a", 8'h61, 8'h61, 1, 1'b0, 1'b0);

    // Right shift alone gives upper case.
    drive(1'b1, 1'b1, 1'b1, 9'h059, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 9'h023, 1'b1, 1'b0);
    check("rshift_D", 8'h44, 8'h44, 1, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kbd_ascii_fifo.md
Name: kbd_ascii_fifo

Overview:
- Successor to the combinational scan-code-to-ASCII table.
- Takes decoded PS/2 key events (make/break, 9-bit code with bit 8 = E0 prefix) and tracks Shift and Caps Lock state.
- Maps letters, digits, shifted digit symbols, space, Enter and Backspace to ASCII, and queues the characters in a parametrised FIFO.
- Sits between the PS/2 keyboard decoder and text consumers (LCD/VGA/UART writers), which drain it through a pop handshake.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
ADDR_W, 4, log2(DEPTH); count is ADDR_W+1 bits
SHIFT_SYMBOLS, 1, 1: Shift+digit emits the US symbol; 0: Shift+digit emits the plain digit

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-low reset; state clears on a rising edge of clk while rst=0
key_valid  in  1  one-cycle pulse; a key event is present this cycle
key_make  in  1  1 = press (make, including typematic repeats), 0 = release (break); sampled with key_valid
last_change  in  9  scan code; bit 8 = E0-extended; sampled with key_valid
clr  in  1  synchronous flush: empties FIFO and clears overflow; Shift/Caps state kept
rd_en  in  1  pop the head entry; ignored when empty
ascii_out  out  8  head entry, first-word-fall-through; 8'h00 when empty
empty  out  1  FIFO empty
full  out  1  FIFO holds DEPTH entries
count  out  ADDR_W+1  number of stored entries
caps_on  out  1  Caps Lock latch state
overflow  out  1  sticky; a character was dropped because the FIFO was full

Behaviour:
- Reset (rst=0 at edge): FIFO pointers=0, count=0, empty=1, full=0, ascii_out=0, caps_on=0, overflow=0, shift_l/shift_r/caps_held=0. Reset overrides clr, rd_en and key_valid.
- Modifier tracking (non-extended codes only):
  - 0x12 sets/clears shift_l on make/break; 0x59 does the same for shift_r.
  - shift = shift_l | shift_r.
  - 0x58 make with caps_held=0: toggle caps_on and set caps_held. 0x58 break clears caps_held, so typematic repeats do not re-toggle.
  - Modifiers never enqueue.
- Mapping, applied on make events only; break events never enqueue:
  - Letters use the existing A-Z code table (1C=A, 32=B, ... 1A=Z). Output is upper case (0x41..0x5A) if shift XOR caps_on, else lower case (0x61..0x7A).
  - Digit codes 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'. With shift=1 and SHIFT_SYMBOLS=1 they map to ) ! @ # $ % ^ & * ( instead. Caps Lock does not affect digits.
  - 0x29 maps to 0x20 (space).
  - 0x5A, and E0 0x5A (bit 8 set), map to 0x0D.
  - 0x66 maps to 0x08 (backspace).
  - Every other code, including all other E0 codes, produces no write.
- Each typematic repeat (make with no intervening break) enqueues again.
- Write timing:
  - A mappable make with key_valid high in cycle n is written at the cycle-n edge.
  - From cycle n+1: empty=0, and ascii_out shows the character if the FIFO was empty.
  - Shift/Caps updates take effect for events from cycle n+1 onward.
- Pop: rd_en=1 and empty=0 advances the read pointer at the edge; ascii_out shows the next entry (or 0) the following cycle.
- Simultaneous write and pop: both are performed and count is unchanged. This holds when full too, where the write is accepted because a slot is freed in the same cycle. When empty, the pop is ignored and the write proceeds.
- Full with no pop: the write is dropped, overflow sets to 1, and contents are unchanged.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- clr=1: pointers and count go to 0 and overflow to 0. Any same-cycle write or pop is discarded. caps_on, shift and caps_held are kept.

Test Plan:
- Reset, then make 0x1C → ascii_out=0x61, count=1. Assert rd_en one cycle → empty=1, ascii_out=0x00.
- Make 0x12, make 0x32, break 0x12, make 0x32 → FIFO holds 0x42, 0x62.
- Caps: make 0x58 three times (typematic), break 0x58 → caps_on=1. Then make 0x12 and make 0x15 → 0x71 (Shift XOR Caps gives lower case).
- Shift+0x16 with SHIFT_SYMBOLS=1 → 0x21; with SHIFT_SYMBOLS=0 → 0x31. E0 0x5A → 0x0D. E0 0x75 and break 0x1C → no write.
- Fill with DEPTH makes of 0x1C, then one more → full=1, overflow=1, count=DEPTH. Next make together with rd_en → count stays DEPTH, the new entry is last, and pointers wrap correctly.
- With caps_on=1 and 3 entries queued, pulse clr → count=0, overflow=0, caps_on=1. Hold rst=0 mid-stream for one edge → all outputs at reset values.
